// File: rtl/mul_sequencer_if.sv
// Execute-stage multiply handshake: request side owned by the pipeline, response side by the sequencer.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic             Accumulate;
  logic             SetFlags;
  logic             Flush;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] SrcC;
  logic             StallE;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [1:0]       FlagW;
  logic [1:0]       ResultNZ;

  modport master (
    output Start, Accumulate, SetFlags, Flush, SrcA, SrcB, SrcC,
    input  StallE, Done, Result, FlagW, ResultNZ
  );

  modport slave (
    input  Start, Accumulate, SetFlags, Flush, SrcA, SrcB, SrcC,
    output StallE, Done, Result, FlagW, ResultNZ
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add MUL/MLA sequencer with early termination, pipeline stall and flush kill.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mul_sequencer_if.slave    bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]  count_q;
  logic              sflag_q;
  logic              done_q;
  logic [1:0]        flagw_q;
  logic [WIDTH-1:0]  result_q;
  logic [1:0]        nz_q;

  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  mcand_d;
  logic [WIDTH-1:0]  mplier_d;
  logic [CNT_W-1:0]  count_d;
  logic              last_d;

  // One shift-and-add step; finishes once no multiplier bits remain or all bits are consumed.
  always_comb begin
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    count_d  = count_q + CNT_W'(1);
    last_d   = (mplier_d == '0) || (count_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      sflag_q  <= 1'b0;
      done_q   <= 1'b0;
      flagw_q  <= 2'b00;
      result_q <= '0;
      nz_q     <= 2'b01;
    end else begin
      done_q  <= 1'b0;
      flagw_q <= 2'b00;
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start && !bus.Flush) begin
            acc_q    <= bus.Accumulate ? bus.SrcC : '0;
            mcand_q  <= bus.SrcA;
            mplier_q <= bus.SrcB;
            count_q  <= '0;
            sflag_q  <= bus.SetFlags;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.Flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            // Outputs are loaded on the final step so they are valid for the whole DONE cycle.
            if (last_d) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              flagw_q  <= sflag_q ? 2'b10 : 2'b00;
              result_q <= acc_d;
              nz_q     <= {acc_d[WIDTH-1], (acc_d == '0)};
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.StallE   = ((state_q == S_IDLE) && bus.Start && !bus.Flush) || (state_q == S_RUN);
  assign bus.Done     = done_q;
  assign bus.FlagW    = flagw_q;
  assign bus.Result   = result_q;
  assign bus.ResultNZ = nz_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_mul_sequencer;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();
  mul_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        accum;
    logic        s;
    logic [31:0] res;
    logic [1:0]  nz;
    logic [1:0]  fw;
    int          k;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_result;
  logic [1:0]  last_nz;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact product plus addend, truncated; latency from position of the top multiplier bit.
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic accum);
    logic [63:0] full;
    full = 64'(a) * 64'(b) + (accum ? 64'(c) : 64'd0);
    return full[31:0];
  endfunction

  function automatic int model_k(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic idle_inputs();
    bus.Start = 1'b0; bus.Accumulate = 1'b0; bus.SetFlags = 1'b0; bus.Flush = 1'b0;
    bus.SrcA = '0; bus.SrcB = '0; bus.SrcC = '0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic accum, input logic s, input logic [31:0] er,
                        input logic [1:0] enz, input logic [1:0] efw, input int ek, input bit noisy);
    @(negedge clk);
    bus.Start = 1'b1; bus.Accumulate = accum; bus.SetFlags = s; bus.Flush = 1'b0;
    bus.SrcA = a; bus.SrcB = b; bus.SrcC = c;
    #1 check("stall_start", 64'(bus.StallE), 64'd1);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    for (int i = 1; i <= ek; i++) begin
      if (noisy) begin
        bus.Start = 1'b1; bus.SrcA = $urandom; bus.SrcB = $urandom; bus.SrcC = $urandom;
        bus.Accumulate = ~accum; bus.SetFlags = ~s;
      end
      #1;
      check("stall_run", 64'(bus.StallE), 64'd1);
      check("done_early", 64'(bus.Done), 64'd0);
      @(posedge clk); #1;
    end
    #1;
    check("done_pulse", 64'(bus.Done), 64'd1);
    check("stall_done", 64'(bus.StallE), 64'd0);
    check("result", 64'(bus.Result), 64'(er));
    check("result_nz", 64'(bus.ResultNZ), 64'(enz));
    check("flagw", 64'(bus.FlagW), 64'(efw));
    @(posedge clk); #1;
    bus.Start = 1'b0;
    #1;
    check("done_after", 64'(bus.Done), 64'd0);
    check("flagw_after", 64'(bus.FlagW), 64'd0);
    check("stall_after", 64'(bus.StallE), 64'd0);
    check("result_hold", 64'(bus.Result), 64'(er));
    last_result = er;
    last_nz     = enz;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_stall", 64'(bus.StallE), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_flagw", 64'(bus.FlagW), 64'd0);
    check("rst_result", 64'(bus.Result), 64'd0);
    check("rst_nz", 64'(bus.ResultNZ), 64'd1);
    last_result = '0;
    last_nz     = 2'b01;
  endtask

  initial begin
    vec_t vecs[6];
    bit   saw_done;

    vecs[0] = '{a: 32'd3, b: 32'd5, c: 32'd0, accum: 1'b0, s: 1'b0,
                res: 32'd15, nz: 2'b00, fw: 2'b00, k: 3};
    vecs[1] = '{a: 32'd7, b: 32'd6, c: 32'd100, accum: 1'b1, s: 1'b1,
                res: 32'd142, nz: 2'b00, fw: 2'b10, k: 3};
    vecs[2] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'd0, accum: 1'b0, s: 1'b1,
                res: 32'h0000_0001, nz: 2'b00, fw: 2'b10, k: 32};
    vecs[3] = '{a: 32'hFFFF_FFFF, b: 32'd2, c: 32'd0, accum: 1'b0, s: 1'b1,
                res: 32'hFFFF_FFFE, nz: 2'b10, fw: 2'b10, k: 2};
    vecs[4] = '{a: 32'd5, b: 32'd0, c: 32'd0, accum: 1'b0, s: 1'b1,
                res: 32'd0, nz: 2'b01, fw: 2'b10, k: 1};
    vecs[5] = '{a: 32'd1, b: 32'd1, c: 32'hFFFF_FFFF, accum: 1'b1, s: 1'b0,
                res: 32'd0, nz: 2'b01, fw: 2'b00, k: 1};

    do_reset();

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].accum, vecs[v].s,
             vecs[v].res, vecs[v].nz, vecs[v].fw, vecs[v].k, 1'b0);

    // Start and operand noise during RUN/DONE must not disturb the op in flight.
    run_op(32'd9, 32'd11, 32'd4, 1'b1, 1'b1, 32'd103, 2'b00, 2'b10, 4, 1'b1);

    // Flush at T+5 of a long op: back to IDLE, no Done, Result keeps prior value.
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd3; bus.SrcB = 32'h8000_0000; bus.SetFlags = 1'b1;
    @(posedge clk); #1 bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.Flush = 1'b1;
    #1 check("flush_stall_run", 64'(bus.StallE), 64'd1);
    @(posedge clk); #1 bus.Flush = 1'b0;
    #1 check("flush_idle_stall", 64'(bus.StallE), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done || bus.StallE) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_result_hold", 64'(bus.Result), 64'(last_result));
    check("flush_nz_hold", 64'(bus.ResultNZ), 64'(last_nz));

    // Start together with Flush in IDLE: nothing starts.
    @(negedge clk);
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.SrcB = 32'h8000_0000;
    #1 check("sf_stall", 64'(bus.StallE), 64'd0);
    @(posedge clk); #1 bus.Start = 1'b0; bus.Flush = 1'b0;
    #1 check("sf_idle", 64'(bus.StallE), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.Done || bus.StallE) saw_done = 1'b1;
    end
    check("sf_no_op", 64'(saw_done), 64'd0);

    // Reset at T+10 of a long op after a nonzero result.
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 32'd15, 2'b00, 2'b10, 3, 1'b0);
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd3; bus.SrcB = 32'h8000_0000; bus.SetFlags = 1'b1;
    @(posedge clk); #1 bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("mid_rst_stall", 64'(bus.StallE), 64'd0);
    check("mid_rst_done", 64'(bus.Done), 64'd0);
    check("mid_rst_flagw", 64'(bus.FlagW), 64'd0);
    check("mid_rst_result", 64'(bus.Result), 64'd0);
    check("mid_rst_nz", 64'(bus.ResultNZ), 64'd1);

    // Random ops vs. the arithmetic model, with varied multiplier magnitude.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] a, b, c, er;
      logic        acc, s;
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      c   = $urandom;
      acc = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      er  = model_result(a, b, c, acc);
      run_op(a, b, c, acc, s, er, {er[31], (er == 32'd0)}, s ? 2'b10 : 2'b00, model_k(b),
             bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
